// File: rtl/dac_event_pkg.sv
// Shared definitions for the DAC spike event detector.
//   det_state_t  : detector FSM state encoding
//   DAC_MIDSCALE : offset-binary zero code of the DAC register
//   SAT_CNT_W    : default width of the window length / saturating event count
package dac_event_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARMED      = 3'd1,
    QUALIFY    = 3'd2,
    ACTIVE     = 3'd3,
    REFRACTORY = 3'd4
  } det_state_t;

  localparam logic [15:0] DAC_MIDSCALE = 16'h8000;

  localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/dac_event_rate_counter.sv
// Per-window event rate counter.
// Counts run edges in a window of window_samples samples, accumulates events
// with saturation and publishes the total once per window.
// Ports:
//   state_clk      in   sample-frame clock
//   reset          in   synchronous, active-high
//   run            in   detector is enabled and out of IDLE
//   event_pulse    in   an event is being qualified on this edge
//   window_samples in   window length in samples, 0 disables counting
//   event_count    out  events counted in the last completed window
//   count_valid    out  one-cycle pulse when event_count updates
module dac_event_rate_counter #(
  parameter int CNT_W = 16
) (
  input  logic             state_clk,
  input  logic             reset,
  input  logic             run,
  input  logic             event_pulse,
  input  logic [CNT_W-1:0] window_samples,
  output logic [CNT_W-1:0] event_count,
  output logic             count_valid
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] evt_acc;
  logic [CNT_W-1:0] acc_next;
  logic [CNT_W-1:0] win_last;

  // Saturating accumulator value including an event on this edge, and the
  // last window position. A window length shrunk below win_cnt simply lets
  // win_cnt wrap once before matching again.
  always_comb begin
    acc_next = evt_acc;
    if (event_pulse && (evt_acc != '1)) begin
      acc_next = evt_acc + CNT_ONE;
    end
    win_last = window_samples - CNT_ONE;
  end

  // Window position, accumulator and published count. Leaving run or a zero
  // window clears the working counters but keeps the last published count.
  always_ff @(posedge state_clk) begin
    if (reset) begin
      win_cnt     <= '0;
      evt_acc     <= '0;
      event_count <= '0;
      count_valid <= 1'b0;
    end else if (!run || (window_samples == '0)) begin
      win_cnt     <= '0;
      evt_acc     <= '0;
      count_valid <= 1'b0;
    end else if (win_cnt == win_last) begin
      event_count <= acc_next;
      count_valid <= 1'b1;
      win_cnt     <= '0;
      evt_acc     <= '0;
    end else begin
      win_cnt     <= win_cnt + CNT_ONE;
      evt_acc     <= acc_next;
      count_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dac_spike_event_detector.sv
// Spike event detector downstream of the DAC output stage.
// Qualifies threshold crossings by minimum width, enforces a refractory dead
// time, captures the peak of each qualified excursion and reports per-window
// event counts.
// Ports:
//   state_clk          in   sample-frame clock, one edge per sample
//   reset              in   synchronous, active-high
//   enable             in   detector enable, low forces IDLE
//   thrsh_in           in   threshold comparator result
//   thrsh_pol          in   1 = track max, 0 = track min (change only while IDLE)
//   dac_value          in   offset-binary DAC value
//   min_width          in   samples above threshold to qualify (0 acts as 1)
//   refractory_samples in   dead samples after an excursion ends
//   window_samples     in   rate window length, 0 disables
//   event_pulse        out  one-cycle pulse on event qualification
//   peak_valid         out  one-cycle pulse when a qualified excursion ends
//   event_peak         out  peak of the last qualified excursion
//   event_count        out  events in the last completed window
//   count_valid        out  one-cycle pulse when event_count updates
//   busy               out  high in QUALIFY, ACTIVE and REFRACTORY
module dac_spike_event_detector
  import dac_event_pkg::*;
#(
  parameter int REFR_W = 8,
  parameter int MINW_W = 4,
  parameter int CNT_W  = SAT_CNT_W
) (
  input  logic              state_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              thrsh_in,
  input  logic              thrsh_pol,
  input  logic [15:0]       dac_value,
  input  logic [MINW_W-1:0] min_width,
  input  logic [REFR_W-1:0] refractory_samples,
  input  logic [CNT_W-1:0]  window_samples,
  output logic              event_pulse,
  output logic              peak_valid,
  output logic [15:0]       event_peak,
  output logic [CNT_W-1:0]  event_count,
  output logic              count_valid,
  output logic              busy
);

  localparam logic [MINW_W-1:0] MINW_ONE = MINW_W'(1);
  localparam logic [REFR_W-1:0] REFR_ONE = REFR_W'(1);

  det_state_t        state_q;
  det_state_t        state_d;
  logic [MINW_W-1:0] width_cnt;
  logic [MINW_W-1:0] width_d;
  logic [MINW_W-1:0] width_inc;
  logic [MINW_W-1:0] eff_minw;
  logic [REFR_W-1:0] refr_cnt;
  logic [REFR_W-1:0] refr_d;
  logic [15:0]       peak_reg;
  logic [15:0]       peak_d;
  logic [15:0]       peak_upd;
  logic              event_fire;
  logic              peak_fire;
  logic              rate_run;

  // Effective width threshold and the running extreme including this sample.
  // Offset-binary codes order correctly as plain unsigned numbers.
  always_comb begin
    eff_minw  = (min_width == '0) ? MINW_ONE : min_width;
    width_inc = width_cnt + MINW_ONE;
    if (thrsh_pol) begin
      peak_upd = (dac_value > peak_reg) ? dac_value : peak_reg;
    end else begin
      peak_upd = (dac_value < peak_reg) ? dac_value : peak_reg;
    end
  end

  // Next-state logic. Dropping enable overrides every state; the sample that
  // ends an excursion is never folded into the peak.
  always_comb begin
    state_d    = state_q;
    width_d    = width_cnt;
    refr_d     = refr_cnt;
    peak_d     = peak_reg;
    event_fire = 1'b0;
    peak_fire  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      width_d = '0;
      refr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (thrsh_in) begin
            width_d = MINW_ONE;
            peak_d  = dac_value;
            if (eff_minw == MINW_ONE) begin
              event_fire = 1'b1;
              state_d    = ACTIVE;
            end else begin
              state_d = QUALIFY;
            end
          end
        end
        QUALIFY: begin
          if (!thrsh_in) begin
            width_d = '0;
            state_d = ARMED;
          end else begin
            width_d = width_inc;
            peak_d  = peak_upd;
            if (width_inc == eff_minw) begin
              event_fire = 1'b1;
              state_d    = ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (thrsh_in) begin
            peak_d = peak_upd;
          end else begin
            peak_fire = 1'b1;
            width_d   = '0;
            if (refractory_samples == '0) begin
              state_d = ARMED;
            end else begin
              refr_d  = refractory_samples;
              state_d = REFRACTORY;
            end
          end
        end
        REFRACTORY: begin
          // Loaded with N, exits on the edge that sees 1: exactly N dead samples.
          refr_d = refr_cnt - REFR_ONE;
          if (refr_cnt == REFR_ONE) begin
            state_d = ARMED;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters, peak tracker and registered pulse outputs.
  always_ff @(posedge state_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      width_cnt   <= '0;
      refr_cnt    <= '0;
      peak_reg    <= '0;
      event_pulse <= 1'b0;
      peak_valid  <= 1'b0;
      event_peak  <= '0;
    end else begin
      state_q     <= state_d;
      width_cnt   <= width_d;
      refr_cnt    <= refr_d;
      peak_reg    <= peak_d;
      event_pulse <= event_fire;
      peak_valid  <= peak_fire;
      if (peak_fire) begin
        event_peak <= peak_reg;
      end
    end
  end

  assign busy = (state_q == QUALIFY) || (state_q == ACTIVE) || (state_q == REFRACTORY);

  // The window only advances on edges where the detector was already out of
  // IDLE, and sees the event being qualified on that same edge.
  assign rate_run = enable && (state_q != IDLE);

  dac_event_rate_counter #(
    .CNT_W(CNT_W)
  ) u_rate (
    .state_clk      (state_clk),
    .reset          (reset),
    .run            (rate_run),
    .event_pulse    (event_fire),
    .window_samples (window_samples),
    .event_count    (event_count),
    .count_valid    (count_valid)
  );

endmodule

// File: tb/tb_dac_spike_event_detector.sv
// Self-checking bench for dac_spike_event_detector: directed scenarios plus
// randomized traffic, scored against a sample-by-sample reference model.
module tb_dac_spike_event_detector;

  logic        state_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        thrsh_in;
  logic        thrsh_pol;
  logic [15:0] dac_value;
  logic [3:0]  min_width;
  logic [7:0]  refractory_samples;
  logic [15:0] window_samples;
  logic        event_pulse;
  logic        peak_valid;
  logic [15:0] event_peak;
  logic [15:0] event_count;
  logic        count_valid;
  logic        busy;

  always #5 state_clk = ~state_clk;

  dac_spike_event_detector dut (
    .state_clk          (state_clk),
    .reset              (reset),
    .enable             (enable),
    .thrsh_in           (thrsh_in),
    .thrsh_pol          (thrsh_pol),
    .dac_value          (dac_value),
    .min_width          (min_width),
    .refractory_samples (refractory_samples),
    .window_samples     (window_samples),
    .event_pulse        (event_pulse),
    .peak_valid         (peak_valid),
    .event_peak         (event_peak),
    .event_count        (event_count),
    .count_valid        (count_valid),
    .busy               (busy)
  );

  typedef struct {
    bit          ep;
    bit          pv;
    bit          cv;
    bit          bz;
    logic [15:0] peak;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // configuration applied with each sample
  bit          cfg_pol;
  logic [3:0]  cfg_mw;
  logic [7:0]  cfg_rf;
  logic [15:0] cfg_ws;

  // reference model state
  bit          m_live;
  bit          m_in_event;
  int          m_len;
  int          m_dead;
  int          m_win_pos;
  int          m_acc;
  logic [15:0] m_peak;
  logic [15:0] m_out_peak;
  logic [15:0] m_cnt;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] more_extreme(input bit pol, input logic [15:0] a, input logic [15:0] b);
    if (pol) return (b > a) ? b : a;
    return (b < a) ? b : a;
  endfunction

  // Drive one sample and push the outputs expected after the edge that takes it.
  task automatic applyStimulus(input bit rst, input bit en, input bit th, input logic [15:0] dac);
    exp_t e;
    int   eff;
    bit   ev;
    @(posedge state_clk);
    #2;
    reset              = rst;
    enable             = en;
    thrsh_in           = th;
    thrsh_pol          = cfg_pol;
    dac_value          = dac;
    min_width          = cfg_mw;
    refractory_samples = cfg_rf;
    window_samples     = cfg_ws;
    e.ep = 0;
    e.pv = 0;
    e.cv = 0;
    if (rst) begin
      m_live = 0; m_in_event = 0; m_len = 0; m_dead = 0;
      m_win_pos = 0; m_acc = 0; m_peak = '0; m_out_peak = '0; m_cnt = '0;
    end else if (!en) begin
      m_live = 0; m_in_event = 0; m_len = 0; m_dead = 0;
      m_win_pos = 0; m_acc = 0;
    end else if (!m_live) begin
      m_live = 1;
    end else begin
      eff = (cfg_mw == 0) ? 1 : int'(cfg_mw);
      ev  = 0;
      if (m_dead > 0) begin
        m_dead--;
      end else if (m_in_event) begin
        if (th) m_peak = more_extreme(cfg_pol, m_peak, dac);
        else begin
          m_out_peak = m_peak;
          e.pv       = 1;
          m_in_event = 0;
          m_dead     = int'(cfg_rf);
        end
      end else if (th) begin
        m_peak = (m_len == 0) ? dac : more_extreme(cfg_pol, m_peak, dac);
        m_len++;
        if (m_len == eff) begin
          ev = 1; e.ep = 1; m_in_event = 1; m_len = 0;
        end
      end else begin
        m_len = 0;
      end
      if (cfg_ws == 0) begin
        m_win_pos = 0;
        m_acc     = 0;
      end else begin
        m_acc = m_acc + int'(ev);
        if (m_acc > 65535) m_acc = 65535;
        if (m_win_pos == int'(cfg_ws) - 1) begin
          m_cnt = 16'(m_acc); e.cv = 1; m_win_pos = 0; m_acc = 0;
        end else begin
          m_win_pos = (m_win_pos + 1) % 65536;
        end
      end
    end
    e.bz   = (m_len > 0) || m_in_event || (m_dead > 0);
    e.peak = m_out_peak;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: after every edge, pop the expected response and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge state_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("event_pulse", 16'(event_pulse), 16'(e.ep));
        checkOutput("peak_valid", 16'(peak_valid), 16'(e.pv));
        checkOutput("count_valid", 16'(count_valid), 16'(e.cv));
        checkOutput("busy", 16'(busy), 16'(e.bz));
        checkOutput("event_peak", event_peak, e.peak);
        checkOutput("event_count", event_count, e.cnt);
      end
    end
  end

  initial begin
    logic [15:0] tp2_vals [5];
    logic [15:0] tp4_vals [3];
    bit          th;
    tp2_vals = '{16'h8100, 16'h8300, 16'h8700, 16'h8200, 16'h8050};
    tp4_vals = '{16'h7F00, 16'h7A00, 16'h7C00};
    reset = 1; enable = 0; thrsh_in = 0; thrsh_pol = 1; dac_value = 16'h8000;
    min_width = 0; refractory_samples = 0; window_samples = 0;
    cfg_pol = 1; cfg_mw = 4'd3; cfg_rf = 8'd0; cfg_ws = 16'd0;

    // reset, with reset dominating enable
    applyStimulus(1, 0, 0, 16'h8000);
    applyStimulus(1, 1, 1, 16'h8000);

    // short excursion below min_width
    applyStimulus(0, 1, 0, 16'h8000);
    applyStimulus(0, 1, 1, 16'h8100);
    applyStimulus(0, 1, 1, 16'h8200);
    applyStimulus(0, 1, 0, 16'h8000);
    applyStimulus(0, 1, 0, 16'h8000);

    // qualified positive excursion with refractory 4
    cfg_mw = 4'd2; cfg_rf = 8'd4;
    applyStimulus(0, 0, 0, 16'h8000);
    applyStimulus(0, 1, 0, 16'h8000);
    foreach (tp2_vals[i]) applyStimulus(0, 1, 1, tp2_vals[i]);
    applyStimulus(0, 1, 0, 16'h8000);
    applyStimulus(0, 1, 1, 16'h9000);
    checkOutput("tp2_peak", event_peak, 16'h8700);
    checkOutput("tp2_peak_valid", 16'(peak_valid), 16'h0001);
    applyStimulus(0, 1, 1, 16'h9100);
    applyStimulus(0, 1, 0, 16'h8000);
    applyStimulus(0, 1, 0, 16'h8000);
    applyStimulus(0, 1, 1, 16'h8400);
    applyStimulus(0, 1, 1, 16'h8500);
    applyStimulus(0, 1, 0, 16'h8000);
    checkOutput("tp3_requalify", 16'(event_pulse), 16'h0001);
    repeat (6) applyStimulus(0, 1, 0, 16'h8000);

    // negative excursion, min_width 0 acts as 1
    cfg_pol = 0; cfg_mw = 4'd0; cfg_rf = 8'd0;
    applyStimulus(0, 0, 0, 16'h8000);
    applyStimulus(0, 1, 0, 16'h8000);
    foreach (tp4_vals[i]) applyStimulus(0, 1, 1, tp4_vals[i]);
    applyStimulus(0, 1, 0, 16'h8000);
    applyStimulus(0, 1, 0, 16'h8000);
    checkOutput("tp4_peak", event_peak, 16'h7A00);

    // window of 10 samples, three events with the last on the 10th
    cfg_pol = 1; cfg_mw = 4'd1; cfg_rf = 8'd0; cfg_ws = 16'd10;
    applyStimulus(0, 0, 0, 16'h8000);
    applyStimulus(0, 1, 0, 16'h8000);
    for (int s = 1; s <= 10; s++) applyStimulus(0, 1, (s == 1) || (s == 4) || (s == 10), 16'h8800);
    applyStimulus(0, 1, 0, 16'h8000);
    checkOutput("tp5_valid", 16'(count_valid), 16'h0001);
    checkOutput("tp5_count3", event_count, 16'd3);
    repeat (9) applyStimulus(0, 1, 0, 16'h8000);
    applyStimulus(0, 1, 0, 16'h8000);
    checkOutput("tp5_valid2", 16'(count_valid), 16'h0001);
    checkOutput("tp5_count0", event_count, 16'd0);

    // enable drop mid-excursion, then reset mid-excursion
    cfg_ws = 16'd0; cfg_rf = 8'd2;
    applyStimulus(0, 1, 1, 16'h9000);
    applyStimulus(0, 1, 1, 16'h9100);
    applyStimulus(0, 0, 1, 16'h9200);
    applyStimulus(0, 1, 1, 16'h9300);
    applyStimulus(0, 1, 1, 16'h9400);
    applyStimulus(1, 1, 1, 16'h9500);
    applyStimulus(0, 1, 0, 16'h8000);
    checkOutput("tp6_peak_zero", event_peak, 16'h0000);
    checkOutput("tp6_busy_zero", 16'(busy), 16'h0000);
    applyStimulus(0, 1, 1, 16'h8900);
    applyStimulus(0, 1, 0, 16'h8000);
    checkOutput("tp6_rearmed", 16'(event_pulse), 16'h0001);

    // randomized phases, configuration changed only while disabled
    for (int p = 0; p < 6; p++) begin
      cfg_pol = 1'($urandom_range(1));
      cfg_mw  = 4'($urandom_range(5));
      cfg_rf  = 8'($urandom_range(6));
      cfg_ws  = ($urandom_range(1) == 0) ? 16'd0 : 16'($urandom_range(15, 3));
      applyStimulus(0, 0, 0, 16'h8000);
      applyStimulus(0, 0, 0, 16'h8000);
      th = 0;
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(3) == 0) th = !th;
        applyStimulus(($urandom_range(255) == 0), ($urandom_range(63) != 0), th,
                      16'($urandom_range(65535)));
      end
    end

    applyStimulus(0, 0, 0, 16'h8000);
    applyStimulus(0, 0, 0, 16'h8000);
    @(posedge state_clk);
    #3;
    checkOutput("drain", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
